// File: rtl/vc_alloc_requester_pkg.sv
// vr_alloc_pkg: shared VC-state encoding and one-hot helper for the VC allocator requestor.
package vr_alloc_pkg;
    typedef enum logic [1:0] {VC_IDLE = 2'b00, VC_WAIT_ALLOC = 2'b01, VC_ACTIVE = 2'b10} vc_state_e;
    function automatic logic is_onehot(input logic [31:0] v);
        return (v != 32'd0) && ((v & (v - 32'd1)) == 32'd0);
    endfunction
endpackage

// File: rtl/onehot_to_bin.sv
// onehot_to_bin: converts a one-hot vector to its binary index.
module onehot_to_bin #(
    parameter int N = 4,
    localparam int W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0] onehot_i,
    output logic [W-1:0] bin_o
);
    always_comb begin
        bin_o = '0;
        for (int k = 0; k < N; k++) bin_o = onehot_i[k] ? (bin_o | W'(k)) : bin_o;
    end
endmodule

// File: rtl/vc_alloc_requester.sv
// vc_alloc_requester: per-input-VC allocation FSMs, request matrix and output-VC ownership bitmap.
module vc_alloc_requester
    import vr_alloc_pkg::*;
#(
    parameter int NUM_VCS     = 4,
    parameter int NUM_OUT_VCS = NUM_VCS,
    parameter int OUTVC_W     = $clog2(NUM_OUT_VCS)
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic [NUM_VCS-1:0]                    head_valid,
    input  logic [NUM_VCS-1:0]                    head_is_head,
    input  logic [NUM_VCS-1:0][NUM_OUT_VCS-1:0]   cand_mask,
    input  logic [NUM_VCS-1:0]                    tail_sent,
    output logic [NUM_VCS-1:0][NUM_OUT_VCS-1:0]   requests,
    input  logic [NUM_VCS-1:0][NUM_OUT_VCS-1:0]   grants,
    output logic [NUM_VCS-1:0]                    vc_active,
    output logic [NUM_VCS-1:0][OUTVC_W-1:0]       vc_out_id,
    output logic [NUM_OUT_VCS-1:0]                outvc_busy,
    output logic                                  alloc_err
);
    vc_state_e                  state_q [NUM_VCS];
    vc_state_e                  state_d [NUM_VCS];
    logic [OUTVC_W-1:0]         out_id_q [NUM_VCS];
    logic [OUTVC_W-1:0]         out_id_d [NUM_VCS];
    logic [OUTVC_W-1:0]         grant_bin [NUM_VCS];
    logic [NUM_OUT_VCS-1:0]     busy_q, busy_d, taken, clr;
    logic [NUM_VCS-1:0]         legal, accept, release_vc;
    logic                       err_q, err_d, dup_own;

    genvar i;
    generate
        for (i = 0; i < NUM_VCS; i++) begin : g_vc
            assign requests[i]   = (state_q[i] == VC_WAIT_ALLOC) ? (cand_mask[i] & ~busy_q) : '0;
            assign legal[i]      = (state_q[i] == VC_WAIT_ALLOC) && is_onehot(32'(grants[i]))
                                   && ((grants[i] & ~requests[i]) == '0);
            assign release_vc[i] = (state_q[i] == VC_ACTIVE) && tail_sent[i];
            assign vc_active[i]  = state_q[i] == VC_ACTIVE;
            assign vc_out_id[i]  = out_id_q[i];
            onehot_to_bin #(.N(NUM_OUT_VCS)) u_o2b (.onehot_i(grants[i]), .bin_o(grant_bin[i]));
            always_comb begin
                state_d[i]  = accept[i] ? VC_ACTIVE : release_vc[i] ? VC_IDLE :
                              (state_q[i] == VC_IDLE && head_valid[i] && head_is_head[i]) ? VC_WAIT_ALLOC : state_q[i];
                out_id_d[i] = accept[i] ? grant_bin[i] : out_id_q[i];
            end
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    state_q[i]  <= VC_IDLE;
                    out_id_q[i] <= '0;
                end else begin
                    state_q[i]  <= state_d[i];
                    out_id_q[i] <= out_id_d[i];
                end
            end
        end
    endgenerate

    // Fixed-priority scan: an output VC already claimed by a lower-index VC rejects later grants.
    always_comb begin
        taken  = '0;
        accept = '0;
        clr    = '0;
        err_d  = err_q;
        for (int k = 0; k < NUM_VCS; k++) begin
            accept[k] = legal[k] && ((grants[k] & taken) == '0);
            taken     = accept[k] ? (taken | grants[k]) : taken;
            clr       = release_vc[k] ? (clr | (NUM_OUT_VCS'(1) << out_id_q[k])) : clr;
            err_d     = err_d | ((grants[k] != '0) && !accept[k])
                              | (tail_sent[k] && state_q[k] != VC_ACTIVE)
                              | (state_q[k] == VC_IDLE && head_valid[k] && !head_is_head[k]);
        end
        busy_d = (busy_q & ~clr) | taken;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_q <= '0;
            err_q  <= 1'b0;
        end else begin
            busy_q <= busy_d;
            err_q  <= err_d;
        end
    end

    assign outvc_busy = busy_q;
    assign alloc_err  = err_q;

    always_comb begin
        dup_own = 1'b0;
        for (int a = 0; a < NUM_VCS; a++)
            for (int b = a + 1; b < NUM_VCS; b++)
                dup_own = dup_own | (state_q[a] == VC_ACTIVE && state_q[b] == VC_ACTIVE && out_id_q[a] == out_id_q[b]);
    end

    a_no_dup_owner: assert property (@(posedge clk) disable iff (reset) !dup_own);
endmodule

// File: tb/tb_vc_alloc_requester.sv
// tb_vc_alloc_requester: scenario tasks with a queue of expected post-grant outcomes.
module tb_vc_alloc_requester;
    logic            clk = 1'b0;
    logic            reset;
    logic [3:0]      head_valid, head_is_head, tail_sent, vc_active, outvc_busy;
    logic [3:0][3:0] cand_mask, requests, grants;
    logic [3:0][1:0] vc_out_id;
    logic            alloc_err;
    int              vectors = 0;
    int              miscompares = 0;

    typedef struct packed {logic [3:0] active; logic [3:0] busy; logic err;} exp_t;
    exp_t exp_q[$];
    exp_t e;

    vc_alloc_requester #(.NUM_VCS(4), .NUM_OUT_VCS(4)) dut (
        .clk(clk), .reset(reset), .head_valid(head_valid), .head_is_head(head_is_head),
        .cand_mask(cand_mask), .tail_sent(tail_sent), .requests(requests), .grants(grants),
        .vc_active(vc_active), .vc_out_id(vc_out_id), .outvc_busy(outvc_busy), .alloc_err(alloc_err)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic pop_check(input string name);
        if (exp_q.size() == 0) begin
            vectors++; miscompares++;
            $display("FAIL %s: scoreboard empty", name);
        end else begin
            e = exp_q.pop_front();
            vectors++; if (vc_active !== e.active) begin miscompares++; $display("FAIL %s_active got %b want %b", name, vc_active, e.active); end
            vectors++; if (outvc_busy !== e.busy) begin miscompares++; $display("FAIL %s_busy got %b want %b", name, outvc_busy, e.busy); end
            vectors++; if (alloc_err !== e.err) begin miscompares++; $display("FAIL %s_err got %b want %b", name, alloc_err, e.err); end
        end
    endtask

    task automatic do_reset;
        reset = 1'b1; head_valid = '0; head_is_head = '0; tail_sent = '0; grants = '0; cand_mask = '0;
        tick;
        reset = 1'b0;
    endtask

    task automatic test_reset;
        #2;
        vectors++; if (requests !== '0) begin miscompares++; $display("FAIL rst_req got %h want 0", requests); end
        vectors++; if (vc_active !== 4'b0) begin miscompares++; $display("FAIL rst_active got %b want 0000", vc_active); end
        vectors++; if (outvc_busy !== 4'b0) begin miscompares++; $display("FAIL rst_busy got %b want 0000", outvc_busy); end
        vectors++; if (vc_out_id !== '0) begin miscompares++; $display("FAIL rst_id got %h want 0", vc_out_id); end
        vectors++; if (alloc_err !== 1'b0) begin miscompares++; $display("FAIL rst_err got %b want 0", alloc_err); end
        tick;
        reset = 1'b0;
    endtask

    task automatic test_basic;
        head_valid = 4'b0001; head_is_head = 4'b0001; cand_mask[0] = 4'b0110;
        tick;
        head_valid = '0; head_is_head = '0;
        vectors++; if (requests[0] !== 4'b0110) begin miscompares++; $display("FAIL basic_req got %b want 0110", requests[0]); end
        grants[0] = 4'b0100;
        exp_q.push_back('{4'b0001, 4'b0100, 1'b0});
        vectors++; if (vc_active[0] !== 1'b0) begin miscompares++; $display("FAIL basic_early_active got %b want 0", vc_active[0]); end
        tick;
        grants = '0;
        pop_check("basic");
        vectors++; if (vc_out_id[0] !== 2'd2) begin miscompares++; $display("FAIL basic_id got %0d want 2", vc_out_id[0]); end
        vectors++; if (requests[0] !== 4'b0000) begin miscompares++; $display("FAIL basic_req_active got %b want 0000", requests[0]); end
    endtask

    task automatic test_masking;
        head_valid = 4'b0010; head_is_head = 4'b0010; cand_mask[1] = 4'b0100;
        tick;
        head_valid = '0; head_is_head = '0;
        for (int c = 0; c < 2; c++) begin
            vectors++; if (requests[1] !== 4'b0000) begin miscompares++; $display("FAIL mask_req_busy got %b want 0000", requests[1]); end
            tick;
        end
        tail_sent = 4'b0001;
        vectors++; if (requests[1] !== 4'b0000) begin miscompares++; $display("FAIL mask_req_tail_cycle got %b want 0000", requests[1]); end
        tick;
        tail_sent = '0;
        vectors++; if (requests[1] !== 4'b0100) begin miscompares++; $display("FAIL mask_req_freed got %b want 0100", requests[1]); end
        vectors++; if (vc_out_id[0] !== 2'd2) begin miscompares++; $display("FAIL mask_id_kept got %0d want 2", vc_out_id[0]); end
        grants[1] = 4'b0100;
        exp_q.push_back('{4'b0010, 4'b0100, 1'b0});
        tick;
        grants = '0;
        pop_check("mask");
        vectors++; if (vc_out_id[1] !== 2'd2) begin miscompares++; $display("FAIL mask_id1 got %0d want 2", vc_out_id[1]); end
        tail_sent = 4'b0010;
        exp_q.push_back('{4'b0000, 4'b0000, 1'b0});
        tick;
        tail_sent = '0;
        pop_check("mask_release");
    endtask

    task automatic test_hold;
        head_valid = 4'b1000; head_is_head = 4'b1000; cand_mask[3] = 4'b1001;
        tick;
        head_valid = '0; head_is_head = '0;
        for (int c = 0; c < 10; c++) begin
            vectors++; if ({requests[3], vc_active[3]} !== 5'b10010) begin miscompares++; $display("FAIL hold_c%0d got req=%b act=%b want req=1001 act=0", c, requests[3], vc_active[3]); end
            tick;
        end
        grants[3] = 4'b1000;
        exp_q.push_back('{4'b1000, 4'b1000, 1'b0});
        tick;
        grants = '0;
        pop_check("hold");
        vectors++; if (vc_out_id[3] !== 2'd3) begin miscompares++; $display("FAIL hold_id got %0d want 3", vc_out_id[3]); end
        tail_sent = 4'b1000;
        tick;
        tail_sent = '0;
    endtask

    task automatic test_back_to_back;
        head_valid = 4'b0001; head_is_head = 4'b0001; cand_mask[0] = 4'b0001;
        tick;
        head_valid = '0; head_is_head = '0;
        grants[0] = 4'b0001;
        exp_q.push_back('{4'b0001, 4'b0001, 1'b0});
        tick;
        grants = '0;
        pop_check("b2b_first");
        tail_sent = 4'b0001; head_valid = 4'b0001; head_is_head = 4'b0001;
        exp_q.push_back('{4'b0000, 4'b0000, 1'b0});
        tick;
        tail_sent = '0;
        pop_check("b2b_idle");
        vectors++; if (requests[0] !== 4'b0000) begin miscompares++; $display("FAIL b2b_no_bypass got %b want 0000", requests[0]); end
        tick;
        head_valid = '0; head_is_head = '0;
        vectors++; if (requests[0] !== 4'b0001) begin miscompares++; $display("FAIL b2b_rewait got %b want 0001", requests[0]); end
        cand_mask[0] = 4'b0011;
        #1;
        vectors++; if (requests[0] !== 4'b0011) begin miscompares++; $display("FAIL b2b_cand_follow got %b want 0011", requests[0]); end
        grants[0] = 4'b0010;
        exp_q.push_back('{4'b0001, 4'b0010, 1'b0});
        tick;
        grants = '0;
        pop_check("b2b_second");
        vectors++; if (vc_out_id[0] !== 2'd1) begin miscompares++; $display("FAIL b2b_id got %0d want 1", vc_out_id[0]); end
        tail_sent = 4'b0001;
        tick;
        tail_sent = '0;
    endtask

    task automatic test_conflict;
        head_valid = 4'b0110; head_is_head = 4'b0110; cand_mask[1] = 4'b0001; cand_mask[2] = 4'b0001;
        tick;
        head_valid = '0; head_is_head = '0;
        vectors++; if ({requests[1], requests[2]} !== 8'b0001_0001) begin miscompares++; $display("FAIL conf_req got %b/%b want 0001/0001", requests[1], requests[2]); end
        grants[1] = 4'b0001; grants[2] = 4'b0001;
        exp_q.push_back('{4'b0010, 4'b0001, 1'b1});
        tick;
        grants = '0;
        pop_check("conf");
        tail_sent = 4'b0010;
        tick;
        tail_sent = '0;
        vectors++; if (requests[2] !== 4'b0001) begin miscompares++; $display("FAIL conf_loser_waiting got %b want 0001", requests[2]); end
    endtask

    task automatic test_multihot;
        head_valid = 4'b0100; head_is_head = 4'b0100; cand_mask[2] = 4'b0011;
        tick;
        head_valid = '0; head_is_head = '0;
        grants[2] = 4'b0011;
        exp_q.push_back('{4'b0000, 4'b0000, 1'b1});
        tick;
        grants = '0;
        pop_check("multihot");
        vectors++; if (requests[2] !== 4'b0011) begin miscompares++; $display("FAIL multihot_still_wait got %b want 0011", requests[2]); end
    endtask

    task automatic test_tail_idle;
        vectors++; if (alloc_err !== 1'b0) begin miscompares++; $display("FAIL err_cleared got %b want 0", alloc_err); end
        tail_sent = 4'b0010;
        exp_q.push_back('{4'b0000, 4'b0000, 1'b1});
        tick;
        tail_sent = '0;
        pop_check("tail_idle");
        vectors++; if (requests !== '0) begin miscompares++; $display("FAIL tail_idle_req got %h want 0", requests); end
    endtask

    task automatic test_reset_midop;
        do_reset;
        head_valid = 4'b0111; head_is_head = 4'b0111;
        cand_mask[0] = 4'b0001; cand_mask[1] = 4'b0010; cand_mask[2] = 4'b0100;
        tick;
        head_valid = '0; head_is_head = '0;
        grants[0] = 4'b0001; grants[1] = 4'b0010; grants[2] = 4'b0100;
        exp_q.push_back('{4'b0111, 4'b0111, 1'b0});
        tick;
        grants = '0;
        pop_check("midop_setup");
        vectors++; if (vc_out_id[2] !== 2'd2) begin miscompares++; $display("FAIL midop_id2 got %0d want 2", vc_out_id[2]); end
        #2;
        reset = 1'b1;
        #1;
        vectors++; if (vc_active !== 4'b0) begin miscompares++; $display("FAIL midop_active got %b want 0000", vc_active); end
        vectors++; if (outvc_busy !== 4'b0) begin miscompares++; $display("FAIL midop_busy got %b want 0000", outvc_busy); end
        vectors++; if (vc_out_id !== '0) begin miscompares++; $display("FAIL midop_id got %h want 0", vc_out_id); end
        tick;
        reset = 1'b0;
        head_valid = 4'b1000; head_is_head = 4'b1000; cand_mask[3] = 4'b1000;
        tick;
        head_valid = '0; head_is_head = '0;
        vectors++; if (requests[3] !== 4'b1000) begin miscompares++; $display("FAIL midop_fresh_req got %b want 1000", requests[3]); end
        grants[3] = 4'b1000;
        exp_q.push_back('{4'b1000, 4'b1000, 1'b0});
        tick;
        grants = '0;
        pop_check("midop_fresh");
    endtask

    initial begin
        reset = 1'b1; head_valid = '0; head_is_head = '0; tail_sent = '0; grants = '0; cand_mask = '0;
        test_reset;
        test_basic;
        test_masking;
        test_hold;
        test_back_to_back;
        test_conflict;
        do_reset;
        test_multihot;
        do_reset;
        test_tail_idle;
        test_reset_midop;
        vectors++; if (exp_q.size() != 0) begin miscompares++; $display("FAIL scoreboard_drain got %0d want 0", exp_q.size()); end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
